// File: rtl/key_event_scanner.sv
// Multi-channel key front end: synchronise, debounce and classify key activity
// into press / release / long-press / auto-repeat pulses per channel.
module key_event_scanner #(
    parameter int NKEYS        = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter int REPEAT_EN    = 1,
    parameter int CNT_W        = 26
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NKEYS-1:0] key,
    input  logic             enable,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] press,
    output logic [NKEYS-1:0] release_o,
    output logic [NKEYS-1:0] long_press,
    output logic [NKEYS-1:0] repeat_o,
    output logic             any_event
);

    localparam longint MAX_AB = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
    localparam longint MAXC   = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
    localparam bit     REP    = (REPEAT_EN != 0);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    if (NKEYS < 1 || NKEYS > 16) begin : g_bad_nkeys
        $fatal(1, "key_event_scanner: NKEYS out of range 1..16");
    end
    if (DEBOUNCE_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cyc
        $fatal(1, "key_event_scanner: DEBOUNCE_CYC and REPEAT_CYC must be >= 2");
    end
    if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
        $fatal(1, "key_event_scanner: LONG_CYC must exceed DEBOUNCE_CYC");
    end
    if (MAXC >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "key_event_scanner: CNT_W too small for cycle counts");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    logic [NKEYS-1:0] sync_q1;
    logic [NKEYS-1:0] sync_q2;
    logic [NKEYS-1:0] sync;
    logic [NKEYS-1:0] lvl;
    logic [CNT_W-1:0] dcnt   [NKEYS];
    logic [CNT_W-1:0] hcnt   [NKEYS];
    logic [CNT_W-1:0] hcnt_n [NKEYS];
    state_t           st     [NKEYS];
    state_t           st_n   [NKEYS];
    logic [NKEYS-1:0] prs_n;
    logic [NKEYS-1:0] rel_n;
    logic [NKEYS-1:0] lng_n;
    logic [NKEYS-1:0] rep_n;

    // Raw keys are active-low; the synchroniser idles in the released state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key;
            sync_q2 <= sync_q1;
        end
    end

    assign sync = ~sync_q2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (sync[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    lvl[i]  <= sync[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NKEYS; i++) begin
                st[i]   <= IDLE;
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                st[i]   <= st_n[i];
                hcnt[i] <= hcnt_n[i];
            end
        end
    end

    // Release is checked first so it pre-empts a long/repeat due the same cycle.
    always_comb begin
        prs_n = '0;
        rel_n = '0;
        lng_n = '0;
        rep_n = '0;
        for (int i = 0; i < NKEYS; i++) begin
            st_n[i]   = st[i];
            hcnt_n[i] = hcnt[i];
            unique case (st[i])
                IDLE: begin
                    if (lvl[i]) begin
                        prs_n[i]  = 1'b1;
                        hcnt_n[i] = '0;
                        st_n[i]   = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!lvl[i]) begin
                        rel_n[i]  = 1'b1;
                        hcnt_n[i] = '0;
                        st_n[i]   = IDLE;
                    end else if (hcnt[i] == LONG_LAST) begin
                        lng_n[i]  = 1'b1;
                        hcnt_n[i] = '0;
                        st_n[i]   = HELD;
                    end else begin
                        hcnt_n[i] = hcnt[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!lvl[i]) begin
                        rel_n[i]  = 1'b1;
                        hcnt_n[i] = '0;
                        st_n[i]   = IDLE;
                    end else if (REP && hcnt[i] == REP_LAST) begin
                        rep_n[i]  = 1'b1;
                        hcnt_n[i] = '0;
                    end else begin
                        hcnt_n[i] = hcnt[i] + 1'b1;
                    end
                end
                default: begin
                    st_n[i]   = IDLE;
                    hcnt_n[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_level  <= '0;
            press      <= '0;
            release_o  <= '0;
            long_press <= '0;
            repeat_o   <= '0;
        end else begin
            key_level  <= lvl;
            press      <= prs_n & {NKEYS{enable}};
            release_o  <= rel_n & {NKEYS{enable}};
            long_press <= lng_n & {NKEYS{enable}};
            repeat_o   <= rep_n & {NKEYS{enable}};
        end
    end

    assign any_event = |(press | release_o | long_press | repeat_o);

endmodule

// File: tb/tb_key_event_scanner.sv
// Directed bench for key_event_scanner with short debounce/long/repeat periods.
`timescale 1ns/1ps
module tb_key_event_scanner;

    localparam int NK = 4;
    localparam int DC = 4;
    localparam int LC = 20;
    localparam int RC = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] key_b = '1;

    logic [NK-1:0] lvl, prs, rel, lng, rep;
    logic          any;
    logic [NK-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;
    logic          any_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_event_scanner #(
        .NKEYS(NK), .DEBOUNCE_CYC(DC), .LONG_CYC(LC),
        .REPEAT_CYC(RC), .REPEAT_EN(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .key(key), .enable(enable),
        .key_level(lvl), .press(prs), .release_o(rel),
        .long_press(lng), .repeat_o(rep), .any_event(any)
    );

    key_event_scanner #(
        .NKEYS(NK), .DEBOUNCE_CYC(DC), .LONG_CYC(LC),
        .REPEAT_CYC(RC), .REPEAT_EN(0), .CNT_W(CW)
    ) dut_norep (
        .clk(clk), .rstn(rstn), .key(key_b), .enable(enable),
        .key_level(lvl_b), .press(prs_b), .release_o(rel_b),
        .long_press(lng_b), .repeat_o(rep_b), .any_event(any_b)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NK-1:0] at(input int e, input int t,
                                        input logic [NK-1:0] v);
        return (e == t) ? v : '0;
    endfunction

    initial begin
        int np, nl, nr, lat;

        // reset and idle
        tick(3);
        chk("rst_out", {lvl, prs, rel, lng, rep, any}, '0);
        rstn = 1'b1;
        for (int e = 0; e < 100; e++) begin
            tick();
            chk("idle", {lvl, prs, rel, lng, rep, any}, '0);
        end

        // key0 long hold with repeats
        for (int e = 0; e <= 50; e++) begin
            key[0] = 1'b0;
            tick();
            chk("k0_lvl", lvl, (e >= 6) ? 4'b0001 : 4'b0000);
            chk("k0_prs", prs, at(e, 6, 4'b0001));
            chk("k0_lng", lng, at(e, 26, 4'b0001));
            chk("k0_rep", rep, (e == 34 || e == 42 || e == 50) ? 4'b0001 : 4'b0000);
        end
        for (int e = 0; e < 8; e++) begin
            key[0] = 1'b1;
            tick();
            chk("k0_rel", rel, at(e, 6, 4'b0001));
            chk("k0_rel_rep", rep, '0);
        end
        tick(10);

        // key1 glitch of three cycles
        for (int e = 0; e < 15; e++) begin
            key[1] = (e >= 3);
            tick();
            chk("glitch", {lvl, any}, '0);
        end

        // key1 clean press then bouncing release
        for (int e = 0; e < 10; e++) begin
            key[1] = 1'b0;
            tick();
            chk("b_prs", prs, at(e, 6, 4'b0010));
        end
        for (int e = 0; e < 16; e++) begin
            key[1] = (e >= 4) ? 1'b1 : ((e % 2) == 0);
            tick();
            chk("b_rel", rel, at(e, 10, 4'b0010));
            chk("b_lvl", lvl, (e < 10) ? 4'b0010 : 4'b0000);
        end
        tick(10);

        // key2 released just before and exactly when long press is due
        for (int h = 19; h <= 20; h++) begin
            for (int e = 0; e < 32; e++) begin
                key[2] = (e >= h);
                tick();
                chk("k2_prs", prs, at(e, 6, 4'b0100));
                chk("k2_rel", rel, at(e, h + 6, 4'b0100));
                chk("k2_lng", lng, '0);
            end
            tick(10);
        end

        // REPEAT_EN=0 instance held 100+ cycles
        np = 0; nl = 0; nr = 0; lat = -1;
        for (int e = 0; e < 106; e++) begin
            key_b[3] = 1'b0;
            tick();
            if (prs_b[3]) np++;
            if (lng_b[3]) begin
                nl++;
                lat = e;
            end
            if (rep_b[3]) nr++;
        end
        chk("nr_press", np, 1);
        chk("nr_long", nl, 1);
        chk("nr_long_at", lat, 26);
        chk("nr_repeat", nr, 0);
        chk("nr_lvl", lvl_b, 4'b1000);
        key_b[3] = 1'b1;
        tick(12);

        // simultaneous presses on key0 and key3
        for (int e = 0; e < 8; e++) begin
            key[0] = 1'b0;
            key[3] = 1'b0;
            tick();
            chk("sim_prs", prs, at(e, 6, 4'b1001));
            chk("sim_any", any, (e == 6));
        end
        for (int e = 0; e < 8; e++) begin
            key[0] = 1'b1;
            key[3] = 1'b1;
            tick();
            chk("sim_rel", rel, at(e, 6, 4'b1001));
        end
        tick(10);

        // enable low over the press, raised mid-hold
        enable = 1'b0;
        for (int e = 0; e <= 26; e++) begin
            key[1] = 1'b0;
            if (e == 10) enable = 1'b1;
            tick();
            chk("en_lvl", lvl, (e >= 6) ? 4'b0010 : 4'b0000);
            chk("en_prs", prs, '0);
            chk("en_lng", lng, at(e, 26, 4'b0010));
        end
        for (int e = 0; e < 8; e++) begin
            key[1] = 1'b1;
            tick();
            chk("en_rel", rel, at(e, 6, 4'b0010));
            chk("en_rep", rep, '0);
        end
        tick(10);

        // reset during HELD
        for (int e = 0; e <= 30; e++) begin
            key[0] = 1'b0;
            tick();
            chk("rh_prs", prs, at(e, 6, 4'b0001));
            chk("rh_lng", lng, at(e, 26, 4'b0001));
        end
        chk("rh_lvl_pre", lvl, 4'b0001);
        rstn = 1'b0;
        #1;
        chk("rh_async", {lvl, prs, rel, lng, rep, any}, '0);
        tick(2);
        chk("rh_hold", {lvl, prs, rel, lng, rep, any}, '0);
        rstn = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick();
            chk("rh_rel", rel, '0);
            chk("rh_prs2", prs, at(e, 6, 4'b0001));
            chk("rh_lvl2", lvl, (e >= 6) ? 4'b0001 : 4'b0000);
        end
        key[0] = 1'b1;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
